// File: rtl/timer_datapath_pkg.sv
// Shared command/terminal-count encodings and display constants
// for the stopwatch/timer controller and its datapath.
package timer_datapath_pkg;

    localparam int MAX_COUNT = 9999;

    localparam logic [2:0] CTR_LOAD  = 3'd0;
    localparam logic [2:0] CTR_UP    = 3'd1;
    localparam logic [2:0] CTR_DOWN  = 3'd2;
    localparam logic [2:0] CTR_CLEAR = 3'd3;

    localparam logic TC_UP   = 1'b0;
    localparam logic TC_DOWN = 1'b1;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/timer_datapath_bcd.sv
// Combinational double-dabble: 14-bit binary to four BCD digits,
// o_bcd[0] is the least significant digit.
module bin_to_bcd4 (
    input  logic [13:0]      i_bin,
    output logic [3:0][3:0]  o_bcd
);

    logic [29:0] w_sr;

    always_comb begin
        w_sr = {16'd0, i_bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (w_sr[14+4*d +: 4] >= 4'd5)
                    w_sr[14+4*d +: 4] = w_sr[14+4*d +: 4] + 4'd3;
            end
            w_sr = w_sr << 1;
        end
        o_bcd = w_sr[29:14];
    end

endmodule

// File: rtl/timer_datapath.sv
// Timer datapath: count/limit registers, 10 ms tick prescaler,
// terminal-count flag and multiplexed seven-segment driver.
module timer_datapath #(
    parameter int TICK_DIV    = 1000000,
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_COUNT   = timer_datapath_pkg::MAX_COUNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_ld_en,
    input  logic        count_en,
    input  logic [2:0]  ctr_select,
    input  logic        tc_select,
    input  logic [16:0] init_val,
    input  logic        an_reset,
    output logic        tc_limit_reached,
    output logic [16:0] synch_init,
    output logic [3:0]  an,
    output logic [6:0]  sseg
);

    import timer_datapath_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [16:0] MAX17 = 17'(MAX_COUNT);

    logic [PW-1:0]     r_presc;
    logic [13:0]       r_count;
    logic [13:0]       r_limit;
    logic [16:0]       r_synch;
    logic              r_tc;
    logic [RW-1:0]     r_refresh;
    logic [1:0]        r_scan;
    logic [3:0]        r_an;
    logic [6:0]        r_sseg;

    logic [16:0]       w_clamped;
    logic [13:0]       w_clamp14;
    logic              w_tick;
    logic [PW-1:0]     w_presc_nxt;
    logic [3:0][3:0]   w_bcd;
    logic [3:0]        w_digit;

    assign w_clamped   = (init_val > MAX17) ? MAX17 : init_val;
    assign w_clamp14   = w_clamped[13:0];
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;

    // Commands only act while count_en is high; prescaler keeps its
    // partial tick across a pause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_limit <= 14'(MAX_COUNT);
            r_synch <= '0;
            r_presc <= '0;
        end else if (count_en) begin
            case (ctr_select)
                CTR_LOAD: begin
                    if (init_ld_en) begin
                        r_count <= w_clamp14;
                        r_synch <= w_clamped;
                        r_presc <= '0;
                    end
                end
                CTR_CLEAR: begin
                    if (init_ld_en) begin
                        r_count <= '0;
                        r_limit <= w_clamp14;
                        r_synch <= w_clamped;
                        r_presc <= '0;
                    end
                end
                CTR_UP: begin
                    r_presc <= w_presc_nxt;
                    if (w_tick && (r_count < r_limit))
                        r_count <= r_count + 1'b1;
                end
                CTR_DOWN: begin
                    r_presc <= w_presc_nxt;
                    if (w_tick && (r_count != '0))
                        r_count <= r_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tc <= 1'b0;
        else if (tc_select == TC_DOWN)
            r_tc <= (r_count == '0);
        else
            r_tc <= (r_count == r_limit);
    end

    bin_to_bcd4 u_bcd (
        .i_bin (r_count),
        .o_bcd (w_bcd)
    );

    assign w_digit = w_bcd[r_scan];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_scan    <= '0;
            r_an      <= 4'b1111;
            r_sseg    <= SEG_BLANK;
        end else if (an_reset) begin
            r_refresh <= '0;
            r_scan    <= '0;
            r_an      <= 4'b1111;
            r_sseg    <= SEG_BLANK;
        end else begin
            if (r_refresh == RW'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_scan    <= r_scan + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an   <= ~(4'b0001 << r_scan);
            r_sseg <= seg_encode(w_digit);
        end
    end

    assign tc_limit_reached = r_tc;
    assign synch_init       = r_synch;
    assign an               = r_an;
    assign sseg             = r_sseg;

endmodule

// File: tb/tb_timer_datapath.sv
// Directed bench for timer_datapath with TICK_DIV=4, REFRESH_DIV=2;
// the count is observed through the scanned display.
module tb_timer_datapath;

    logic        clk;
    logic        reset;
    logic        init_ld_en;
    logic        count_en;
    logic [2:0]  ctr_select;
    logic        tc_select;
    logic [16:0] init_val;
    logic        an_reset;
    logic        tc_limit_reached;
    logic [16:0] synch_init;
    logic [3:0]  an;
    logic [6:0]  sseg;

    int tests = 0;
    int fails = 0;

    timer_datapath #(
        .TICK_DIV    (4),
        .REFRESH_DIV (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .init_ld_en       (init_ld_en),
        .count_en         (count_en),
        .ctr_select       (ctr_select),
        .tc_select        (tc_select),
        .init_val         (init_val),
        .an_reset         (an_reset),
        .tc_limit_reached (tc_limit_reached),
        .synch_init       (synch_init),
        .an               (an),
        .sseg             (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int seg2dig(input logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            default:    return 15;
        endcase
    endfunction

    // Scan 8 display slots; a missing or bad digit yields a wrong value.
    task automatic read_count(output int v);
        int d0, d1, d2, d3;
        d0 = 15; d1 = 15; d2 = 15; d3 = 15;
        step(1);
        repeat (8) begin
            @(negedge clk);
            case (an)
                4'b1110: d0 = seg2dig(sseg);
                4'b1101: d1 = seg2dig(sseg);
                4'b1011: d2 = seg2dig(sseg);
                4'b0111: d3 = seg2dig(sseg);
                default: ;
            endcase
        end
        v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    endtask

    initial begin
        int v;
        reset      = 1'b0;
        init_ld_en = 1'b0;
        count_en   = 1'b0;
        ctr_select = 3'd4;
        tc_select  = 1'b0;
        init_val   = '0;
        an_reset   = 1'b0;
        step(2);
        chk("rst_an", an, 4'b1111);
        chk("rst_sseg", sseg, 7'b1111111);
        chk("rst_tc", tc_limit_reached, 0);
        chk("rst_synch", synch_init, 0);
        reset = 1'b1;

        // CLEAR to 9999, then to 1200
        count_en   = 1'b1;
        ctr_select = 3'd3;
        init_ld_en = 1'b1;
        init_val   = 17'd9999;
        step(1);
        chk("clr_synch_9999", synch_init, 9999);
        init_val = 17'd1200;
        step(1);
        chk("clr_synch_1200", synch_init, 1200);

        // UP to the limit
        init_ld_en = 1'b0;
        ctr_select = 3'd1;
        step(4800);
        chk("up_tc_latency", tc_limit_reached, 0);
        step(1);
        chk("up_tc_set", tc_limit_reached, 1);
        step(40);
        chk("up_tc_hold", tc_limit_reached, 1);
        count_en = 1'b0;
        read_count(v);
        chk("up_count_1200", v, 1200);

        // LOAD clamps, then DOWN to zero
        count_en   = 1'b1;
        ctr_select = 3'd0;
        init_ld_en = 1'b1;
        init_val   = 17'd20000;
        step(1);
        chk("ld_clamp_synch", synch_init, 9999);
        count_en   = 1'b0;
        init_ld_en = 1'b0;
        read_count(v);
        chk("ld_count_9999", v, 9999);
        tc_select  = 1'b1;
        ctr_select = 3'd2;
        count_en   = 1'b1;
        step(39996);
        chk("dn_tc_latency", tc_limit_reached, 0);
        step(1);
        chk("dn_tc_set", tc_limit_reached, 1);
        step(20);
        chk("dn_tc_hold", tc_limit_reached, 1);
        count_en = 1'b0;
        read_count(v);
        chk("dn_no_wrap", v, 0);

        // Pause with prescaler at 2
        count_en   = 1'b1;
        ctr_select = 3'd0;
        init_ld_en = 1'b1;
        init_val   = 17'd0;
        step(1);
        init_ld_en = 1'b0;
        ctr_select = 3'd1;
        tc_select  = 1'b0;
        step(2);
        count_en = 1'b0;
        step(41);
        read_count(v);
        chk("pause_count", v, 0);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        read_count(v);
        chk("resume_1cyc", v, 0);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        read_count(v);
        chk("resume_2cyc", v, 1);

        // Display scan of 1234
        count_en   = 1'b1;
        ctr_select = 3'd0;
        init_ld_en = 1'b1;
        init_val   = 17'd1234;
        an_reset   = 1'b1;
        step(1);
        chk("disp_blank_an", an, 4'b1111);
        chk("disp_blank_sseg", sseg, 7'b1111111);
        chk("disp_synch", synch_init, 1234);
        count_en   = 1'b0;
        init_ld_en = 1'b0;
        an_reset   = 1'b0;
        step(1);
        chk("d0_an", an, 4'b1110);
        chk("d0_sseg", sseg, 7'b0011001);
        step(1);
        chk("d0_an_hold", an, 4'b1110);
        step(1);
        chk("d1_an", an, 4'b1101);
        chk("d1_sseg", sseg, 7'b0110000);
        step(2);
        chk("d2_an", an, 4'b1011);
        chk("d2_sseg", sseg, 7'b0100100);
        step(2);
        chk("d3_an", an, 4'b0111);
        chk("d3_sseg", sseg, 7'b1111001);
        step(2);
        chk("wrap_an", an, 4'b1110);
        an_reset = 1'b1;
        step(1);
        chk("anrst_an", an, 4'b1111);
        chk("anrst_sseg", sseg, 7'b1111111);
        an_reset = 1'b0;

        // Async reset mid-DOWN at 500
        count_en   = 1'b1;
        ctr_select = 3'd3;
        init_ld_en = 1'b1;
        init_val   = 17'd500;
        step(1);
        ctr_select = 3'd0;
        step(1);
        init_ld_en = 1'b0;
        ctr_select = 3'd2;
        step(2);
        chk("mid_tc", tc_limit_reached, 1);
        chk("mid_synch", synch_init, 500);
        reset = 1'b0;
        #1;
        chk("async_an", an, 4'b1111);
        chk("async_sseg", sseg, 7'b1111111);
        chk("async_tc", tc_limit_reached, 0);
        chk("async_synch", synch_init, 0);
        step(1);
        reset      = 1'b1;
        ctr_select = 3'd1;
        step(3);
        count_en = 1'b0;
        read_count(v);
        chk("post_rst_3cyc", v, 0);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        read_count(v);
        chk("post_rst_tick", v, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
